// File: rtl/led_pattern_gen.sv
// Purpose: LED pattern generator: prescaled up/down counter with a selectable LED window, chase, blink, freeze.
// Latency: led/step/wrap are registered; led trails a cnt/pos/phase update by one clock.
// Backpressure: none; en low holds all pattern state, load is honoured regardless of en.
//
// Parameters:
//   CNT_W  main counter width (a multiple of LED_W)
//   LED_W  LED bank width (>= 2)
//   SEL_W  window-select width; CNT_W/LED_W windows exist
//   DIV    prescale divisor (>= 1); one counter step per DIV enabled clocks
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   en             prescaler/step enable
//   mode           00 COUNT, 01 CHASE, 10 BLINK, 11 FREEZE
//   dir            counter direction (1 up, 0 down)
//   sel            counter window shown in COUNT mode
//   load, load_val synchronous counter load (wins over a step)
//   duty           PWM duty (only when LED_PATTERN_PWM_EN is defined)
//   led            registered LED drive
//   step, wrap     registered one-cycle pulses per counter step / counter wrap
// Build option: define LED_PATTERN_PWM_EN to add the duty input and PWM dimming of led.

module led_pattern_gen #(
  parameter int CNT_W = 32,
  parameter int LED_W = 16,
  parameter int SEL_W = 1,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef LED_PATTERN_PWM_EN
  input  logic [7:0]       duty,
`endif
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam int NWIN  = CNT_W / LED_W;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W = $clog2(LED_W);

  typedef enum logic [1:0] {
    M_COUNT  = 2'b00,
    M_CHASE  = 2'b01,
    M_BLINK  = 2'b10,
    M_FREEZE = 2'b11
  } mode_t;

  typedef enum logic {
    FWD = 1'b0,
    BWD = 1'b1
  } chase_dir_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [POS_W-1:0] pos_q,   pos_d;
  chase_dir_t       chase_q, chase_d;
  logic             phase_q, phase_d;
  mode_t            mode_q,  mode_d;
  logic [LED_W-1:0] led_q,   led_d;
  logic             step_q,  step_d;
  logic             wrap_q,  wrap_d;
`ifdef LED_PATTERN_PWM_EN
  logic [7:0]       pwm_q,   pwm_d;
  // Ungated pattern; FREEZE must hold the pattern, not a PWM-chopped sample of it.
  logic [LED_W-1:0] led_raw_q;
`endif

  mode_t            mode_in;
  logic             step_cond;
  logic             chase_entry;
  logic             blink_entry;
  logic [LED_W-1:0] win;
  logic [LED_W-1:0] onehot;
  logic [LED_W-1:0] led_hold;
  logic [LED_W-1:0] led_raw_d;

  assign mode_in = mode_t'(mode);

  // ---------------------------------------------------------------------------
  // Prescaler and counter
  // ---------------------------------------------------------------------------
  // A load suppresses the step in the same cycle, so step/wrap stay low on load.
  assign step_cond = en && !load && (pre_q == PRE_W'(DIV - 1));

  always_comb begin
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = step_cond ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    step_d = step_cond;
    if (load) begin
      cnt_d = load_val;
    end else if (step_cond) begin
      if (dir) begin
        cnt_d  = cnt_q + CNT_W'(1);
        wrap_d = &cnt_q;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
        wrap_d = ~|cnt_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode tracking: entry into CHASE/BLINK re-initialises that mode's state and
  // overrides any step that happens in the same cycle.
  // ---------------------------------------------------------------------------
  assign mode_d      = mode_in;
  assign chase_entry = (mode_in == M_CHASE) && (mode_q != M_CHASE);
  assign blink_entry = (mode_in == M_BLINK) && (mode_q != M_BLINK);

  // Chase position bounces between the two ends; dir has no influence here.
  always_comb begin
    pos_d   = pos_q;
    chase_d = chase_q;
    if (chase_entry) begin
      pos_d   = '0;
      chase_d = FWD;
    end else if (step_cond && (mode_in == M_CHASE)) begin
      if (chase_q == FWD) begin
        if (pos_q == POS_W'(LED_W - 1)) begin
          pos_d   = POS_W'(LED_W - 2);
          chase_d = BWD;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d   = POS_W'(1);
          chase_d = FWD;
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (blink_entry) begin
      phase_d = 1'b0;
    end else if (step_cond && (mode_in == M_BLINK)) begin
      phase_d = ~phase_q;
    end
  end

  // ---------------------------------------------------------------------------
  // LED pattern selection. Sources are the registered cnt/pos/phase, which is
  // what gives led its one-clock lag behind those updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Out-of-range sel leaves the window at zero.
    win = '0;
    for (int w = 0; w < NWIN; w++) begin
      if (int'(sel) == w) begin
        win = cnt_q[w*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (int'(pos_q) == i) begin
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  assign led_hold = led_raw_q;
`else
  assign led_hold = led_q;
`endif

  always_comb begin
    led_raw_d = led_hold;
    case (mode_in)
      M_COUNT:  led_raw_d = win;
      M_CHASE:  led_raw_d = onehot;
      M_BLINK:  led_raw_d = {LED_W{phase_q}};
      default:  led_raw_d = led_hold;
    endcase
  end

`ifdef LED_PATTERN_PWM_EN
  // Free-running dimmer, independent of en; gating lands in the same output
  // register as the pattern so PWM adds no latency.
  assign pwm_d = pwm_q + 8'd1;
  assign led_d = led_raw_d & {LED_W{(pwm_q < duty)}};
`else
  assign led_d = led_raw_d;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pre_q     <= '0;
      pos_q     <= '0;
      chase_q   <= FWD;
      phase_q   <= 1'b0;
      mode_q    <= M_COUNT;
      led_q     <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef LED_PATTERN_PWM_EN
      pwm_q     <= '0;
      led_raw_q <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      pos_q     <= pos_d;
      chase_q   <= chase_d;
      phase_q   <= phase_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
`ifdef LED_PATTERN_PWM_EN
      pwm_q     <= pwm_d;
      led_raw_q <= led_raw_d;
`endif
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Purpose: self-checking bench for led_pattern_gen (COUNT/load/wrap/window, CHASE, BLINK/FREEZE, reset, PWM build).
// Latency: expected led/step/wrap are queued per clock and compared one clock edge after the inputs are applied.
// Backpressure: none; the stimulus queues one expectation per clock and the monitor pops one per clock.

module tb_led_pattern_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic        dir;
  logic [1:0]  sel;
  logic        load;
  logic [31:0] load_val;
`ifdef LED_PATTERN_PWM_EN
  logic [7:0]  duty;
`endif

  logic [15:0] led_a;
  logic        step_a, wrap_a;
  logic [3:0]  led_b;
  logic        step_b, wrap_b;
  logic [3:0]  led_c;
  logic        step_c, wrap_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          id;
    logic [15:0] led;
    logic        cl;
    logic        step;
    logic        wrap;
    logic        cs;
    logic [127:0] nm;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] chase_seq [0:9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: 32-bit counter, 16-bit LEDs, two windows, step every clock.
  led_pattern_gen #(.CNT_W(32), .LED_W(16), .SEL_W(2), .DIV(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .sel(sel),
    .load(load), .load_val(load_val),
`ifdef LED_PATTERN_PWM_EN
    .duty(duty),
`endif
    .led(led_a), .step(step_a), .wrap(wrap_a)
  );

  // B: 4-bit LEDs, step every 4 clocks (chase).
  led_pattern_gen #(.CNT_W(8), .LED_W(4), .SEL_W(2), .DIV(4)) u_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .sel(sel),
    .load(load), .load_val(load_val[7:0]),
`ifdef LED_PATTERN_PWM_EN
    .duty(duty),
`endif
    .led(led_b), .step(step_b), .wrap(wrap_b)
  );

  // C: 4-bit LEDs, step every 3 clocks (blink / freeze / PWM).
  led_pattern_gen #(.CNT_W(8), .LED_W(4), .SEL_W(2), .DIV(3)) u_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .sel(sel),
    .load(load), .load_val(load_val[7:0]),
`ifdef LED_PATTERN_PWM_EN
    .duty(duty),
`endif
    .led(led_c), .step(step_c), .wrap(wrap_c)
  );

  task automatic chk(input logic [127:0] nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %0s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue the expectation for the coming clock edge, then let that edge pass.
  task automatic cyc(input int id, input logic [15:0] eled, input logic cl,
                     input logic es, input logic ew, input logic cs, input logic [127:0] nm);
    exp_t e;
    e.id   = id;
    e.led  = eled;
    e.cl   = cl;
    e.step = es;
    e.wrap = ew;
    e.cs   = cs;
    e.nm   = nm;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t        e;
    logic [15:0] act_led;
    logic        act_step, act_wrap;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.id)
          0:       begin act_led = led_a;          act_step = step_a; act_wrap = wrap_a; end
          1:       begin act_led = {12'b0, led_b}; act_step = step_b; act_wrap = wrap_b; end
          default: begin act_led = {12'b0, led_c}; act_step = step_c; act_wrap = wrap_c; end
        endcase
        if (e.cl) chk({e.nm, ".led"}, {16'b0, act_led}, {16'b0, e.led});
        if (e.cs) begin
          chk({e.nm, ".step"}, {31'b0, act_step}, {31'b0, e.step});
          chk({e.nm, ".wrap"}, {31'b0, act_wrap}, {31'b0, e.wrap});
        end
      end
    end
  end

  initial begin
    chase_seq[0] = 4'b0001; chase_seq[1] = 4'b0010; chase_seq[2] = 4'b0100;
    chase_seq[3] = 4'b1000; chase_seq[4] = 4'b0100; chase_seq[5] = 4'b0010;
    chase_seq[6] = 4'b0001; chase_seq[7] = 4'b0010; chase_seq[8] = 4'b0100;
    chase_seq[9] = 4'b1000;

    reset = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b1; sel = 2'd0;
    load = 1'b0; load_val = 32'h0;
`ifdef LED_PATTERN_PWM_EN
    duty = 8'd255;
`endif
    @(negedge clk);

    // Reset state on every instance.
    cyc(0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_a");
    cyc(1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_b");
    cyc(2, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_c");

`ifndef LED_PATTERN_PWM_EN
    // ---------------- COUNT on A ----------------
    reset = 1'b0; en = 1'b1; mode = 2'b00; sel = 2'd0; dir = 1'b1;
    for (int k = 0; k < 5; k++) cyc(0, 16'(k), 1'b1, 1'b1, 1'b0, 1'b1, "count_up");

    load = 1'b1; load_val = 32'hFFFF_FFFE; sel = 2'd1;
    cyc(0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "load");
    load = 1'b0;
    cyc(0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, "ld_ffff");
    cyc(0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, "wrap_up");
    cyc(0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, "post_wrap");
    dir = 1'b0;
    cyc(0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, "down");
    cyc(0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, "wrap_dn");
    cyc(0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, "dn_ones");
    sel = 2'd0;
    cyc(0, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b1, "sel0");
    sel = 2'd2;
    cyc(0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, "sel_oob");
    sel = 2'd0; en = 1'b0;
    for (int k = 0; k < 10; k++) cyc(0, 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b1, "en_hold");
    load = 1'b1; load_val = 32'h0001_2345;
    cyc(0, 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b1, "ld_en0");
    load = 1'b0;
    cyc(0, 16'h2345, 1'b1, 1'b0, 1'b0, 1'b1, "ld_en0_lo");
    sel = 2'd1;
    cyc(0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, "ld_en0_hi");

    // ---------------- CHASE on B ----------------
    reset = 1'b1; mode = 2'b01; en = 1'b1; dir = 1'b1; sel = 2'd0;
    cyc(1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_chase");
    reset = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      dir = (k > 32) ? 1'b0 : 1'b1;  // counter direction must not steer the chase
      cyc(1, {12'b0, chase_seq[(k-1)/4]}, 1'b1, (k % 4) == 0, 1'b0, 1'b1, "chase");
    end
    // Position is now 3; pulse reset between edges.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1, (k == 5) ? 16'h2 : 16'h1, 1'b1, k == 4, k == 4, 1'b1, "chase_rst");
    end

    // ---------------- BLINK / FREEZE on C ----------------
    reset = 1'b1; mode = 2'b10; dir = 1'b1; en = 1'b1;
    cyc(2, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_blink");
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(2, (((k-1)/3) % 2 == 1) ? 16'hF : 16'h0, 1'b1, (k % 3) == 0, 1'b0, 1'b1, "blink");
    end
    mode = 2'b11;
    for (int k = 11; k <= 18; k++) begin
      cyc(2, 16'hF, 1'b1, (k % 3) == 0, 1'b0, 1'b1, "freeze");
    end
`else
    // ---------------- PWM on C ----------------
    begin
      int hi;
      int odd;
      reset = 1'b0; mode = 2'b10; en = 1'b1; duty = 8'd255;
      repeat (5) @(negedge clk);
      mode = 2'b11; duty = 8'd64;
      repeat (2) @(negedge clk);
      hi = 0; odd = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        if (led_c == 4'hF) hi++;
        else if (led_c != 4'h0) odd++;
      end
      chk("pwm64_on", 32'(hi), 32'd64);
      chk("pwm64_partial", 32'(odd), 32'd0);
      duty = 8'd0;
      repeat (2) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        if (led_c != 4'h0) hi++;
      end
      chk("pwm0_on", 32'(hi), 32'd0);
    end
`endif

    for (int g = 0; g < 4 && sb_q.size() > 0; g++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
